// File: rtl/multi_strand_register_file_pkg.sv
// Shared definitions for the multi-strand register file: clear-sequencer
// state encoding and the default array geometry.
package multi_strand_register_file_pkg;

   typedef enum logic [1:0] {
      CLEAR_ALL    = 2'd0,
      CLEAR_STRAND = 2'd1,
      READY        = 2'd2
   } rf_state_e;

   localparam int DEFAULT_DATA_WIDTH      = 32;
   localparam int DEFAULT_NUM_STRANDS     = 4;
   localparam int DEFAULT_REGS_PER_STRAND = 32;

endpackage

// File: rtl/multi_strand_register_file_clear_sequencer.sv
// Clear sequencer: sweeps zeroes through the whole array after reset, or
// through one strand on request, and reports when normal access is allowed.
module rf_clear_sequencer
   import multi_strand_register_file_pkg::*;
#(
   parameter  int NUM_STRANDS     = DEFAULT_NUM_STRANDS,
   parameter  int REGS_PER_STRAND = DEFAULT_REGS_PER_STRAND,
   localparam int NUM_REGISTERS   = NUM_STRANDS * REGS_PER_STRAND,
   localparam int ADDR_WIDTH      = $clog2(NUM_REGISTERS),
   localparam int STRAND_WIDTH    = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1,
   localparam int REG_WIDTH       = $clog2(REGS_PER_STRAND)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_strand_i,
   input  logic [STRAND_WIDTH-1:0] clear_strand_id_i,
   output logic                    clear_we,
   output logic [ADDR_WIDTH-1:0]   clear_addr,
   output logic                    ready
);

   rf_state_e                state, state_next;
   logic [ADDR_WIDTH-1:0]    count, count_next;
   logic [STRAND_WIDTH-1:0]  strand_q, strand_next;
   logic [ADDR_WIDTH-1:0]    strand_addr;

   // ready is registered from the next state so it tracks the FSM exactly
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= CLEAR_ALL;
         count    <= '0;
         strand_q <= '0;
         ready    <= 1'b0;
      end else begin
         state    <= state_next;
         count    <= count_next;
         strand_q <= strand_next;
         ready    <= (state_next == READY);
      end
   end

   always_comb begin
      state_next  = state;
      count_next  = count;
      strand_next = strand_q;
      case (state)
         CLEAR_ALL: begin
            count_next = count + ADDR_WIDTH'(1);
            if (count == ADDR_WIDTH'(NUM_REGISTERS - 1)) begin
               state_next = READY;
               count_next = '0;
            end
         end
         CLEAR_STRAND: begin
            count_next = count + ADDR_WIDTH'(1);
            if (count[REG_WIDTH-1:0] == REG_WIDTH'(REGS_PER_STRAND - 1)) begin
               state_next = READY;
               count_next = '0;
            end
         end
         READY: begin
            if (clear_strand_i) begin
               state_next  = CLEAR_STRAND;
               count_next  = '0;
               strand_next = clear_strand_id_i;
            end
         end
         default: begin
            state_next = CLEAR_ALL;
            count_next = '0;
         end
      endcase
   end

   // A single-strand file has no strand field in its index
   if (NUM_STRANDS > 1) begin : g_strand_addr
      assign strand_addr = {strand_q, count[REG_WIDTH-1:0]};
   end else begin : g_flat_addr
      assign strand_addr = count;
   end

   assign clear_addr = (state == CLEAR_STRAND) ? strand_addr : count;
   assign clear_we   = (state != READY);

endmodule

// File: rtl/multi_strand_register_file.sv
// Multi-strand scalar register file: two registered read ports with
// same-cycle write bypass, one write port, and a hardware clear sequencer.
module multi_strand_register_file
   import multi_strand_register_file_pkg::*;
#(
   parameter  int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
   parameter  int NUM_STRANDS     = DEFAULT_NUM_STRANDS,
   parameter  int REGS_PER_STRAND = DEFAULT_REGS_PER_STRAND,
   localparam int NUM_REGISTERS   = NUM_STRANDS * REGS_PER_STRAND,
   localparam int ADDR_WIDTH      = $clog2(NUM_REGISTERS),
   localparam int STRAND_WIDTH    = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   sel1_i,
   input  logic [ADDR_WIDTH-1:0]   sel2_i,
   output logic [DATA_WIDTH-1:0]   value1_o,
   output logic [DATA_WIDTH-1:0]   value2_o,
   input  logic [ADDR_WIDTH-1:0]   write_reg_i,
   input  logic [DATA_WIDTH-1:0]   write_value_i,
   input  logic                    write_enable_i,
   input  logic                    clear_strand_i,
   input  logic [STRAND_WIDTH-1:0] clear_strand_id_i,
   output logic                    ready_o
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGISTERS];
   logic                  seq_we;
   logic                  seq_ready;
   logic [ADDR_WIDTH-1:0] seq_addr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   rf_clear_sequencer #(
      .NUM_STRANDS     (NUM_STRANDS),
      .REGS_PER_STRAND (REGS_PER_STRAND)
   ) u_clear_sequencer (
      .clk               (clk),
      .reset             (reset),
      .clear_strand_i    (clear_strand_i),
      .clear_strand_id_i (clear_strand_id_i),
      .clear_we          (seq_we),
      .clear_addr        (seq_addr),
      .ready             (seq_ready)
   );

   assign ready_o = seq_ready;

   // The sequencer owns the write port whenever normal access is closed
   assign wr_en   = !reset && (seq_ready ? write_enable_i : seq_we);
   assign wr_addr = seq_ready ? write_reg_i : seq_addr;
   assign wr_data = seq_ready ? write_value_i : '0;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Each port forwards the incoming write on an index match
   always_ff @(posedge clk) begin
      if (reset || !seq_ready) begin
         value1_o <= '0;
         value2_o <= '0;
      end else begin
         value1_o <= (write_enable_i && write_reg_i == sel1_i) ? write_value_i : regs_q[sel1_i];
         value2_o <= (write_enable_i && write_reg_i == sel2_i) ? write_value_i : regs_q[sel2_i];
      end
   end

endmodule
